// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: loader word stream in, instruction-cache write port out
interface fetch_sequencer_if;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        wr_instr_en_o;
  logic [31:0] wr_instr_o;
  logic [63:0] wr_addr_o;
  modport slave (input ld_valid_i, ld_data_i, output ld_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o);
  modport master (output ld_valid_i, ld_data_i, input ld_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads a program into the instruction cache, then sequences core reset, fetch enables and branch flushes
module fetch_sequencer #(
  parameter int MAX_WORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_start_i,
  input  logic [15:0]          load_count_i,
  input  logic                 halt_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  fetch_sequencer_if.slave     bus,
  output logic                 core_rst_o,
  output logic                 pc_en_o,
  output logic                 if_en_o,
  output logic                 pc_src_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam int CW = $clog2(MAX_WORDS) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_max_q, lc;
  logic          accept, last, wr_en_q;
  logic [31:0]   wr_data_q;
  logic [63:0]   wr_addr_q;
  assign lc = (32'(load_count_i) > MAX_WORDS) ? CW'(MAX_WORDS) : CW'(load_count_i);
  assign accept = state_q == LOAD && bus.ld_valid_i;
  assign last = cnt_q == cnt_max_q - CW'(1);
  assign bus.ld_ready_o = state_q == LOAD;
  assign bus.wr_instr_en_o = wr_en_q;
  assign bus.wr_instr_o = wr_data_q;
  assign bus.wr_addr_o = wr_addr_q;
  always_comb begin
    state_d = state_q;
    core_rst_o = 1'b0;
    pc_en_o = 1'b0;
    if_en_o = 1'b0;
    pc_src_o = 1'b0;
    flush_o = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        core_rst_o = 1'b1;
        if (load_start_i) state_d = (lc == '0) ? START : LOAD;
      end
      LOAD: begin
        busy_o = 1'b1;
        if (accept && last) state_d = START;
      end
      START: begin
        core_rst_o = 1'b1;
        done_o = 1'b1;
        busy_o = 1'b1;
        state_d = RUN;
      end
      RUN, FLUSH: begin
        pc_en_o = ~stall_i;
        if_en_o = ~stall_i;
        flush_o = state_q == FLUSH;
        // halt wins over a same-cycle branch, so no redirect is issued
        if (halt_i) state_d = IDLE;
        else if (branch_taken_i) begin
          pc_src_o = 1'b1;
          pc_en_o = 1'b1;
          flush_o = 1'b1;
          state_d = FLUSH;
        end else state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cnt_max_q <= '0;
      wr_en_q <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= accept;
      if (state_q == IDLE && load_start_i) begin
        cnt_max_q <= lc;
        cnt_q <= '0;
      end else if (accept) begin
        wr_data_q <= bus.ld_data_i;
        wr_addr_q <= {{(62-CW){1'b0}}, cnt_q, 2'b00};
        cnt_q <= (cnt_q < CW'(MAX_WORDS)) ? cnt_q + CW'(1) : cnt_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of load, start, run, branch flush, halt and reset behaviour
module tb_fetch_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic load_start_i = 1'b0;
  logic [15:0] load_count_i = '0;
  logic halt_i = 1'b0;
  logic stall_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic core_rst_o, pc_en_o, if_en_o, pc_src_o, flush_o, busy_o, done_o;
  int n_tests = 0;
  int n_fail = 0;
  fetch_sequencer_if bus ();
  fetch_sequencer #(.MAX_WORDS(1024)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_start_i(load_start_i), .load_count_i(load_count_i),
    .halt_i(halt_i), .stall_i(stall_i), .branch_taken_i(branch_taken_i), .bus(bus),
    .core_rst_o(core_rst_o), .pc_en_o(pc_en_o), .if_en_o(if_en_o), .pc_src_o(pc_src_o),
    .flush_o(flush_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk_i);
  endtask
  initial begin
    int wcnt;
    logic [63:0] last_addr;
    logic done_seen;
    bus.ld_valid_i = 1'b0;
    bus.ld_data_i = '0;
    #2;
    check("rst core_rst", core_rst_o, 1);
    check("rst ld_ready", bus.ld_ready_o, 0);
    check("rst wr_en", bus.wr_instr_en_o, 0);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst pc_en", pc_en_o, 0);
    step();
    rst_ni = 1'b1;
    // three-word load with gaps in the stream
    step();
    load_start_i = 1'b1;
    load_count_i = 16'd3;
    #1 check("idle ld_ready", bus.ld_ready_o, 0);
    step();
    load_start_i = 1'b0;
    #1 check("load ld_ready", bus.ld_ready_o, 1);
    check("load busy", busy_o, 1);
    step();
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i = 32'hAAAA_0001;
    step();
    bus.ld_valid_i = 1'b0;
    #1 check("wrA en", bus.wr_instr_en_o, 1);
    check("wrA data", bus.wr_instr_o, 64'hAAAA_0001);
    check("wrA addr", bus.wr_addr_o, 0);
    step();
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i = 32'hBBBB_0002;
    #1 check("gap wr_en", bus.wr_instr_en_o, 0);
    step();
    bus.ld_data_i = 32'hCCCC_0003;
    #1 check("wrB data", bus.wr_instr_o, 64'hBBBB_0002);
    check("wrB addr", bus.wr_addr_o, 4);
    step();
    bus.ld_data_i = 32'hDDDD_0004;
    #1 check("start ld_ready", bus.ld_ready_o, 0);
    check("start done", done_o, 1);
    check("start core_rst", core_rst_o, 1);
    check("wrC en", bus.wr_instr_en_o, 1);
    check("wrC data", bus.wr_instr_o, 64'hCCCC_0003);
    check("wrC addr", bus.wr_addr_o, 8);
    step();
    bus.ld_valid_i = 1'b0;
    #1 check("run done", done_o, 0);
    check("run busy", busy_o, 0);
    check("run core_rst", core_rst_o, 0);
    check("no extra wr", bus.wr_instr_en_o, 0);
    check("run pc_en", pc_en_o, 1);
    check("run if_en", if_en_o, 1);
    step();
    stall_i = 1'b1;
    #1 check("stall pc_en", pc_en_o, 0);
    check("stall if_en", if_en_o, 0);
    // branch overrides stall, flush then holds with stall
    branch_taken_i = 1'b1;
    #1 check("br pc_src", pc_src_o, 1);
    check("br pc_en", pc_en_o, 1);
    check("br flush", flush_o, 1);
    step();
    branch_taken_i = 1'b0;
    #1 check("fl flush", flush_o, 1);
    check("fl pc_en", pc_en_o, 0);
    check("fl pc_src", pc_src_o, 0);
    step();
    stall_i = 1'b0;
    #1 check("back run flush", flush_o, 0);
    check("back run pc_en", pc_en_o, 1);
    branch_taken_i = 1'b1;
    step();
    #1 check("fl rebranch src", pc_src_o, 1);
    step();
    branch_taken_i = 1'b0;
    #1 check("fl again flush", flush_o, 1);
    check("fl again src", pc_src_o, 0);
    step();
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    #1 check("run ignores load", busy_o, 0);
    halt_i = 1'b1;
    branch_taken_i = 1'b1;
    #1 check("halt pc_src", pc_src_o, 0);
    step();
    halt_i = 1'b0;
    branch_taken_i = 1'b0;
    #1 check("halt core_rst", core_rst_o, 1);
    check("halt pc_en", pc_en_o, 0);
    check("halt flush", flush_o, 0);
    // zero-length load goes straight to START
    load_start_i = 1'b1;
    load_count_i = 16'd0;
    step();
    load_start_i = 1'b0;
    #1 check("z done", done_o, 1);
    check("z ld_ready", bus.ld_ready_o, 0);
    check("z wr_en", bus.wr_instr_en_o, 0);
    step();
    #1 check("z run core_rst", core_rst_o, 0);
    check("z run wr_en", bus.wr_instr_en_o, 0);
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    // oversized load clamps to capacity
    load_start_i = 1'b1;
    load_count_i = 16'd5000;
    step();
    load_start_i = 1'b0;
    bus.ld_valid_i = 1'b1;
    wcnt = 0;
    last_addr = '0;
    done_seen = 1'b0;
    for (int i = 0; i < 1100 && !done_seen; i++) begin
      step();
      bus.ld_data_i = 32'(i);
      #1;
      if (bus.wr_instr_en_o) begin
        wcnt++;
        last_addr = bus.wr_addr_o;
      end
      done_seen = done_o;
    end
    bus.ld_valid_i = 1'b0;
    check("big done seen", done_seen, 1);
    check("big writes", wcnt, 1024);
    check("big last addr", last_addr, 64'hFFC);
    step();
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    // reset mid-load aborts immediately
    load_start_i = 1'b1;
    load_count_i = 16'd4;
    step();
    load_start_i = 1'b0;
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i = 32'h1111_0000;
    step();
    bus.ld_data_i = 32'h2222_0000;
    step();
    #1 check("pre-rst wr_en", bus.wr_instr_en_o, 1);
    rst_ni = 1'b0;
    #1 check("arst wr_en", bus.wr_instr_en_o, 0);
    check("arst ld_ready", bus.ld_ready_o, 0);
    check("arst core_rst", core_rst_o, 1);
    check("arst busy", busy_o, 0);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check("post-rst ld_ready", bus.ld_ready_o, 0);
      check("post-rst wr_en", bus.wr_instr_en_o, 0);
    end
    bus.ld_valid_i = 1'b0;
    load_start_i = 1'b1;
    load_count_i = 16'd1;
    step();
    load_start_i = 1'b0;
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i = 32'h3333_0000;
    step();
    bus.ld_valid_i = 1'b0;
    #1 check("reload data", bus.wr_instr_o, 64'h3333_0000);
    check("reload addr", bus.wr_addr_o, 0);
    check("reload done", done_o, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024, meaning instruction cache capacity in 32-bit words (power of two).
REQ-002 SHALL have ports: clk_i in 1 system clock; rst_ni in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: load_start_i in 1 begin program load; load_count_i in 16 number of words to load.
REQ-004 SHALL have ports: ld_valid_i in 1 and ld_data_i in 32 for the loader word stream; ld_ready_o out 1 for word accept.
REQ-005 SHALL have ports: halt_i in 1 stop core; stall_i in 1 hazard stall; branch_taken_i in 1 branch resolved in EX.
REQ-006 SHALL have ports: wr_instr_en_o out 1, wr_instr_o out 32, wr_addr_o out 64 (byte address), all driving the cache write port.
REQ-007 SHALL have ports: core_rst_o out 1 (fetch/PC reset), pc_en_o out 1, if_en_o out 1, pc_src_o out 1, flush_o out 1, busy_o out 1, done_o out 1.

Function
REQ-008 SHALL implement states IDLE, LOAD, START, RUN, FLUSH.
REQ-009 IDLE: core_rst_o=1, pc_en_o=if_en_o=0, ld_ready_o=0; on load_start_i, latch min(load_count_i, MAX_WORDS) and clear word counter.
REQ-010 IDLE + load_start_i with count 0: SHALL go to START directly, with no cache writes.
REQ-011 IDLE + load_start_i with count >0: SHALL go to LOAD.
REQ-012 LOAD: ld_ready_o=1; each cycle with ld_valid_i=1 is one accepted word.
REQ-013 Accepted word: on the next cycle SHALL assert wr_instr_en_o for exactly one cycle, with wr_instr_o=ld_data_i and wr_addr_o=counter*4 (zero-extended); counter then increments.
REQ-014 Final word accepted (counter==count-1): SHALL drop ld_ready_o the next cycle and go to START; no word beyond count is accepted.
REQ-015 load_start_i in LOAD, START, RUN or FLUSH SHALL be ignored.
REQ-016 START: SHALL last one cycle with core_rst_o=1 and pulse done_o=1, then go to RUN; the last write is guaranteed complete before START exits.
REQ-017 RUN: core_rst_o=0; pc_en_o=if_en_o=~stall_i; pc_src_o=0; flush_o=0.
REQ-018 RUN + branch_taken_i: SHALL drive pc_src_o=1, pc_en_o=1 and flush_o=1 in the same cycle (branch overrides stall), then go to FLUSH.
REQ-019 FLUSH: SHALL hold flush_o=1, pc_src_o=0 and pc_en_o=~stall_i for one cycle, then return to RUN; branch_taken_i in FLUSH SHALL be treated as in RUN (re-enters FLUSH).
REQ-020 halt_i in RUN or FLUSH SHALL go to IDLE on the next cycle; halt_i outranks a simultaneous branch_taken_i (no pc_src_o pulse); halt_i is ignored in IDLE, LOAD and START.
REQ-021 busy_o SHALL be 1 in LOAD and START and 0 elsewhere.
REQ-022 The word counter SHALL be log2(MAX_WORDS)+1 bits wide and SHALL never wrap: it saturates at MAX_WORDS.

Reset
REQ-023 rst_ni low SHALL asynchronously force IDLE, counter=0, latched count=0, and all outputs 0 except core_rst_o=1.
REQ-024 Reset asserted mid-LOAD SHALL abort the load immediately with no further wr_instr_en_o; release lands in IDLE.

Verification
REQ-025 Load 3 words A,B,C with gaps in ld_valid_i: writes occur at addr 0,4,8; START lasts 1 cycle; done_o pulses once; RUN is entered.
REQ-026 load_count_i=0: IDLE -> START -> RUN; no wr_instr_en_o.
REQ-027 RUN with stall_i=1 and branch_taken_i=1: pc_src_o=pc_en_o=flush_o=1 that cycle; flush_o=1 on the next cycle with pc_en_o=0.
REQ-028 halt_i and branch_taken_i together in RUN: next state IDLE; pc_src_o=0; core_rst_o=1 from the next cycle.
REQ-029 load_count_i=5000 with MAX_WORDS=1024: exactly 1024 writes, last at addr 0xFFC, then START.
REQ-030 rst_ni pulsed low after 2 of 4 words: outputs reset immediately; ld_ready_o=0; IDLE holds until a new load_start_i.
